// File: rtl/riscv_defs.sv
// Shared RISC-V front-end constants: datapath width and canonical NOP.
// The decode stage imports the same definitions.
package riscv_defs;

  localparam int unsigned RV_XLEN = 32;

  // ADDI x0,x0,0
  localparam logic [RV_XLEN-1:0] RV_NOP_INSTR = 32'h0000_0013;

endpackage : riscv_defs

// File: rtl/fetch_decode_queue_mem.sv
// DEPTH x WIDTH register array for the fetch/decode queue.
// It has one synchronous write port and one asynchronous read port.
module fetch_decode_queue_mem #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage is deliberately left out of reset; count/pointers already mark it
  // invalid, and a resettable array would block mapping onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : fetch_decode_queue_mem

// File: rtl/fetch_decode_queue.sv
// Instruction buffer between fetch and decode. It holds {pc, instruction} pairs in
// FIFO order, drops everything on flush, and shows a NOP to decode when it is empty.
module fetch_decode_queue
  import riscv_defs::*;
#(
  parameter int unsigned    XLEN      = RV_XLEN,
  parameter int unsigned    DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(RV_NOP_INSTR)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instruction,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instruction,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned     PW         = $clog2(DEPTH);
  localparam int unsigned     CW         = $clog2(DEPTH+1);
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;
  logic [2*XLEN-1:0] w_rd_data;

  // Both handshakes depend only on registered count, so nothing combinational
  // links in_* to out_* or out_ready to in_ready.
  assign in_ready  = (r_count != FULL_COUNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid  & in_ready  & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= PW'(r_wr_ptr + PW'(1));
      if (w_pop)  r_rd_ptr <= PW'(r_rd_ptr + PW'(1));
      case ({w_push, w_pop})
        2'b10:   r_count <= CW'(r_count + CW'(1));
        2'b01:   r_count <= CW'(r_count - CW'(1));
        default: r_count <= r_count;
      endcase
    end
  end

  fetch_decode_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({in_pc, in_instruction}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  assign out_pc          = out_valid ? w_rd_data[2*XLEN-1:XLEN] : '0;
  assign out_instruction = out_valid ? w_rd_data[XLEN-1:0]      : NOP_INSTR;
  assign count           = r_count;

endmodule : fetch_decode_queue

// File: tb/tb_fetch_decode_queue.sv
// Directed and random bench for fetch_decode_queue. A scoreboard queue tracks
// accepted entries, and every cycle's outputs are compared against it.
module tb_fetch_decode_queue;

  localparam int unsigned    XLEN  = 32;
  localparam int unsigned    DEPTH = 2;
  localparam logic [31:0]    NOP   = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_instruction;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_instruction;
  logic [1:0]       count;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] sb[$];

  fetch_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_instruction  (in_instruction),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instruction (out_instruction),
    .count           (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare outputs against the scoreboard mid-cycle, then predict the coming edge.
  task automatic step();
    int n;
    bit m_push, m_pop;
    logic [63:0] head;
    @(negedge clk);
    n = sb.size();
    check("count", 64'(count), 64'(n));
    check("out_valid", 64'(out_valid), 64'(n != 0));
    check("in_ready", 64'(in_ready), 64'(n != DEPTH));
    if (n == 0) begin
      check("empty_pc", 64'(out_pc), 64'd0);
      check("empty_instr", 64'(out_instruction), 64'(NOP));
    end else begin
      head = sb[0];
      check("head_pc", 64'(out_pc), 64'(head[63:32]));
      check("head_instr", 64'(out_instruction), 64'(head[31:0]));
    end
    m_push = in_valid && (n != DEPTH) && !flush;
    m_pop  = out_ready && (n != 0) && !flush;
    if (flush) sb.delete();
    else begin
      if (m_pop)  void'(sb.pop_front());
      if (m_push) sb.push_back({in_pc, in_instruction});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
    in_valid       = v;
    in_pc          = pc;
    in_instruction = pc ^ 32'hC0DE_0000;
    out_ready      = rdy;
    flush          = fl;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_out_instr", 64'(out_instruction), 64'(NOP));
    reset = 1'b0;

    // Asynchronous reset in the middle of a cycle while the queue is full.
    drive(1'b1, 32'h100, 1'b0, 1'b0); step();
    drive(1'b1, 32'h104, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0,   1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_out_instr", 64'(out_instruction), 64'(NOP));
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;

    // Fill with out_ready low; a third push is ignored while full.
    drive(1'b1, 32'h0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h4, 1'b0, 1'b0); step();
    drive(1'b1, 32'h8, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    step();
    step();

    // Streaming: one in, one out per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    step();

    // Flush beats a simultaneous push and pop.
    drive(1'b1, 32'h10, 1'b0, 1'b0); step();
    drive(1'b1, 32'h14, 1'b1, 1'b1); step();
    drive(1'b0, 32'h0,  1'b1, 1'b0); step();
    check("post_flush_out_valid", 64'(out_valid), 64'd0);
    step();

    // Wrap-around: fill then drain, three times.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        drive(1'b1, 32'h200 + 32'(r * 16 + k * 4), 1'b0, 1'b0);
        step();
      end
      for (int k = 0; k < DEPTH + 1; k++) begin
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
      end
    end

    // Random traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      in_valid       = 1'($urandom_range(0, 1));
      in_pc          = 32'h1000 + 32'(i * 4);
      in_instruction = $urandom;
      out_ready      = 1'($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 19) == 0);
      step();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (DEPTH + 1) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_decode_queue
